// File: rtl/key_schedule_seq_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 key-schedule engine.
package keyexp_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, EXP} state_t;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic word_t rot_word(input word_t x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_seq_sub_word.sv
// Combinational AES SubWord: four parallel byte S-box lookups.
module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    o_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_word[8*i +: 8] = SBOX[i_word[8*i +: 8]];
    end
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one word per clock.
// Optional KEYEXP_SBOX_PIPE_EN registers the S-box output, adding one EXP cycle per round.
module key_schedule_seq
  import keyexp_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         done_o
);

`ifdef KEYEXP_SBOX_PIPE_EN
  localparam logic [2:0] K_FIRST = 3'd1;
  localparam logic [2:0] K_LAST  = 3'd4;
`else
  localparam logic [2:0] K_FIRST = 3'd0;
  localparam logic [2:0] K_LAST  = 3'd3;
`endif

  state_t     r_state, w_next;
  word_t      r_w0, r_w1, r_w2, r_w3;
  logic [7:0] r_rcon;
  logic [3:0] r_round;
  logic [2:0] r_k;
  logic       r_done;

  logic  w_start, w_xfer, w_last, w_shift;
  word_t w_sub_in, w_sub_out, w_g, w_new;

  assign w_start  = (r_state == IDLE) && start_i;
  assign w_xfer   = (r_state == EMIT) && rk_ready_i;
  assign w_last   = (r_round == NUM_ROUNDS[3:0]);
  assign w_sub_in = rot_word(r_w3);

  sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

`ifdef KEYEXP_SBOX_PIPE_EN
  word_t r_sb;
  // k==0 only captures the S-box result; words are produced on k=1..4.
  assign w_shift = (r_state == EXP) && (r_k != 3'd0);
  assign w_g     = r_sb ^ {r_rcon, 24'h0};
`else
  assign w_shift = (r_state == EXP);
  assign w_g     = w_sub_out ^ {r_rcon, 24'h0};
`endif

  assign w_new = r_w0 ^ ((r_k == K_FIRST) ? w_g : r_w3);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_next = EMIT;
      EMIT: if (rk_ready_i) w_next = w_last ? IDLE : EXP;
      EXP:  if (r_k == K_LAST) w_next = EMIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
      r_rcon  <= RCON_INIT;
      r_round <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
`ifdef KEYEXP_SBOX_PIPE_EN
      r_sb    <= '0;
`endif
    end else begin
      r_done <= w_xfer && w_last;
      if (w_start) begin
        {r_w0, r_w1, r_w2, r_w3} <= key_i;
        r_round <= '0;
        r_rcon  <= RCON_INIT;
        r_k     <= '0;
      end
      if (w_xfer && !w_last) begin
        r_round <= r_round + 4'd1;
        r_k     <= '0;
      end
      if (r_state == EXP) begin
        r_k <= r_k + 3'd1;
        if (r_k == K_FIRST) r_rcon <= xtime(r_rcon);
      end
      if (w_shift) begin
        r_w0 <= r_w1;
        r_w1 <= r_w2;
        r_w2 <= r_w3;
        r_w3 <= w_new;
      end
`ifdef KEYEXP_SBOX_PIPE_EN
      if (r_state == EXP && r_k == 3'd0) r_sb <= w_sub_out;
`endif
    end
  end

  assign busy_o     = (r_state != IDLE);
  assign rk_valid_o = (r_state == EMIT);
  assign rk_o       = {r_w0, r_w1, r_w2, r_w3};
  assign rk_idx_o   = r_round;
  assign done_o     = r_done;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_key_schedule_seq;

  localparam int unsigned NR = 10;
`ifdef KEYEXP_SBOX_PIPE_EN
  localparam int SPACING = 6;
`else
  localparam int SPACING = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_i, start_i, rk_ready_i;
  logic [127:0] key_i;
  logic         busy_o, rk_valid_o, done_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;

  always #5 clk = ~clk;

  key_schedule_seq #(.NUM_ROUNDS(NR)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .key_i      (key_i),
    .busy_o     (busy_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .rk_o       (rk_o),
    .rk_idx_o   (rk_idx_o),
    .done_o     (done_o)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [127:0] FIPS [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZKEY1 = 128'h62636363626363636263636362636363;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and tracks done/spacing.
  int   cyc = 0;
  int   last_rise = -1;
  logic prev_valid = 1'b0;
  logic exp_done = 1'b0;
  logic spacing_en = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_done) begin
      chk("done_pulse", {127'b0, done_o}, 128'd1);
      exp_done = 1'b0;
    end else if (done_o) begin
      chk("done_spurious", {127'b0, done_o}, 128'd0);
    end
    if (!rst_i && rk_valid_o && rk_ready_i) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_key: got idx %0d, want none", rk_idx_o);
      end else begin
        e = sbq.pop_front();
        chk("rk_idx", {124'b0, rk_idx_o}, {124'b0, e.idx});
        chk("rk", rk_o, e.rk);
        if (e.idx == NR[3:0]) exp_done = 1'b1;
      end
    end
    if (rk_valid_o && !prev_valid) begin
      if (spacing_en && rk_idx_o != 4'd0 && last_rise >= 0)
        chk("spacing", 128'(cyc - last_rise), 128'(SPACING));
      last_rise = cyc;
    end
    prev_valid = rk_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fips();
    for (int i = 0; i <= 10; i++) sbq.push_back('{idx: 4'(i), rk: FIPS[i]});
  endtask

  task automatic start_run(input logic [127:0] k);
    key_i   = k;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Returns #1 after the clock edge on which key idx transferred.
  task automatic wait_xfer(input int idx);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rk_valid_o && rk_ready_i && rk_idx_o == 4'(idx)) break;
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL timeout_xfer: got no transfer, want idx %0d", idx);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rk_ready_i = 1'b0; key_i = '0;
    tick();
    tick();
    chk("rst_busy", {127'b0, busy_o}, 128'd0);
    chk("rst_valid", {127'b0, rk_valid_o}, 128'd0);
    chk("rst_done", {127'b0, done_o}, 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    chk("rst_idx", {124'b0, rk_idx_o}, 128'd0);
    rst_i = 1'b0;
    tick();

    // 1: full FIPS run, no backpressure
    rk_ready_i = 1'b1;
    spacing_en = 1'b1;
    push_fips();
    start_run(FIPS[0]);
    chk("t1_latency_valid", {127'b0, rk_valid_o}, 128'd1);
    chk("t1_busy", {127'b0, busy_o}, 128'd1);
    wait_xfer(10);
    chk("t1_idle_after", {127'b0, busy_o}, 128'd0);
    spacing_en = 1'b0;
    tick();
    tick();

    // 2: seven stall cycles at each key
    rk_ready_i = 1'b0;
    push_fips();
    start_run(FIPS[0]);
    for (int r = 0; r <= 10; r++) begin
      for (int s = 0; s < 7; s++) begin
        chk("t2_valid", {127'b0, rk_valid_o}, 128'd1);
        chk("t2_idx", {124'b0, rk_idx_o}, 128'(r));
        chk("t2_rk", rk_o, FIPS[r]);
        tick();
      end
      rk_ready_i = 1'b1;
      tick();
      rk_ready_i = 1'b0;
      if (r < 10) begin
        for (int n = 0; n < 20 && !rk_valid_o; n++) tick();
      end
    end
    tick();
    tick();

    // 3: start with another key during round-3 expansion is ignored
    rk_ready_i = 1'b1;
    push_fips();
    start_run(FIPS[0]);
    wait_xfer(2);
    key_i   = ~FIPS[0];
    start_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      chk("t3_busy", {127'b0, busy_o}, 128'd1);
      tick();
    end
    start_i = 1'b0;
    wait_xfer(10);
    tick();
    tick();

    // 4: reset at round 5, k=2, then zero key
    push_fips();
    start_run(FIPS[0]);
    wait_xfer(4);
    tick();
    tick();
    rst_i = 1'b1;
    sbq.delete();
    tick();
    chk("t4_busy", {127'b0, busy_o}, 128'd0);
    chk("t4_valid", {127'b0, rk_valid_o}, 128'd0);
    chk("t4_rk", rk_o, 128'd0);
    chk("t4_idx", {124'b0, rk_idx_o}, 128'd0);
    rst_i = 1'b0;
    tick();
    sbq.push_back('{idx: 4'd0, rk: 128'd0});
    sbq.push_back('{idx: 4'd1, rk: ZKEY1});
    start_run(128'd0);
    wait_xfer(1);
    rk_ready_i = 1'b0;
    chk("t4_queue_drained", 128'(sbq.size()), 128'd0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // 5: start accepted in the done_o cycle
    rk_ready_i = 1'b1;
    push_fips();
    start_run(FIPS[0]);
    wait_xfer(10);
    chk("t5_done_now", {127'b0, done_o}, 128'd1);
    push_fips();
    start_run(FIPS[0]);
    chk("t5_valid", {127'b0, rk_valid_o}, 128'd1);
    chk("t5_idx", {124'b0, rk_idx_o}, 128'd0);
    wait_xfer(10);
    tick();
    tick();

    chk("final_queue_empty", 128'(sbq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
